sample_block_averager: RTL

Downstream consumer of the sample buffer queue. Accepts 8-bit samples over a valid/ready handshake at a throttled rate, matching a processing unit slower than the sampler. Reduces each block of BLOCK_LEN samples to average, minimum and maximum. Presents the result on a held output handshake. While it throttles or holds a result, backpressure is what makes the upstream queue fill.

---
 rtl/sample_pkg.sv | 18 +
 rtl/sample_block_averager_if.sv | 28 ++
 rtl/sample_pacer.sv | 29 ++
 rtl/sample_block_averager.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/sample_pkg.sv
// Shared types and sizing helpers for the sample-averaging consumer path.
package sample_pkg;

  localparam int DEF_DATA_W = 8;

  typedef logic [DEF_DATA_W-1:0] sample_t;

  typedef enum logic {
    ACCUM  = 1'b0,
    RESULT = 1'b1
  } avg_state_t;

  // Accumulator width that holds BLOCK_LEN full-scale samples without wrapping.
  function automatic int sum_w(input int data_w, input int block_len);
    return data_w + $clog2(block_len);
  endfunction

endpackage

// File: rtl/sample_block_averager_if.sv
// Sample-in / block-result-out handshake bundle for the block averager.
interface sample_block_averager_if
  import sample_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_avg;
  logic [DATA_W-1:0] out_min;
  logic [DATA_W-1:0] out_max;
  logic [15:0]       out_seq;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_avg, out_min, out_max, out_seq
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_avg, out_min, out_max, out_seq
  );

endinterface

// File: rtl/sample_pacer.sv
// Throttle for slow consumers: after each accept, holds ready_ok low for
// PROC_INTERVAL-1 cycles, then stays high until the next accept.
module sample_pacer #(
  parameter int PROC_INTERVAL = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic accept,
  output logic ready_ok
);

  localparam int                PACE_W = 8;
  localparam logic [PACE_W-1:0] RELOAD = PACE_W'(PROC_INTERVAL - 1);

  logic [PACE_W-1:0] pace_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pace_q <= '0;
    end else if (accept) begin
      pace_q <= RELOAD;
    end else if (pace_q != '0) begin
      pace_q <= pace_q - 1'b1;
    end
  end

  assign ready_ok = (pace_q == '0);

endmodule

// File: rtl/sample_block_averager.sv
// Reduces each block of BLOCK_LEN paced samples to truncated average, min and
// max, then holds the result on the output handshake until it is taken.
module sample_block_averager
  import sample_pkg::*;
#(
  parameter int DATA_W        = DEF_DATA_W,
  parameter int BLOCK_LEN     = 4,
  parameter int PROC_INTERVAL = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  sample_block_averager_if.slave  bus
);

  localparam int                  LOG2_LEN = $clog2(BLOCK_LEN);
  localparam int                  SUM_W    = sum_w(DATA_W, BLOCK_LEN);
  localparam logic [LOG2_LEN-1:0] LAST_CNT = LOG2_LEN'(BLOCK_LEN - 1);

  avg_state_t          state_q;
  avg_state_t          state_d;
  logic [LOG2_LEN-1:0] cnt_q;
  logic [SUM_W-1:0]    sum_q;
  logic [SUM_W-1:0]    sum_d;
  logic [DATA_W-1:0]   min_q;
  logic [DATA_W-1:0]   max_q;
  logic [DATA_W-1:0]   min_d;
  logic [DATA_W-1:0]   max_d;
  logic [DATA_W-1:0]   avg_out_q;
  logic [DATA_W-1:0]   min_out_q;
  logic [DATA_W-1:0]   max_out_q;
  logic [15:0]         seq_q;
  logic                ready_ok;
  logic                in_ready;
  logic                accept;
  logic                last;
  logic                take;

  // Power-of-two block length makes the mean a plain right shift.
  function automatic logic [DATA_W-1:0] trunc_avg(input logic [SUM_W-1:0] s);
    return s[SUM_W-1:LOG2_LEN];
  endfunction

  function automatic logic [DATA_W-1:0] min_of(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [DATA_W-1:0] max_of(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  assign in_ready = (state_q == ACCUM) && ready_ok;
  assign accept   = bus.in_valid && in_ready;
  assign last     = accept && (cnt_q == LAST_CNT);
  assign take     = (state_q == RESULT) && bus.out_ready;

  sample_pacer #(
    .PROC_INTERVAL (PROC_INTERVAL)
  ) u_pacer (
    .clk      (clk),
    .rst      (rst),
    .accept   (accept),
    .ready_ok (ready_ok)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (last)          state_d = RESULT;
      RESULT:  if (bus.out_ready) state_d = ACCUM;
      default:                    state_d = ACCUM;
    endcase
  end

  // Running statistics including the sample being offered this cycle.
  always_comb begin
    sum_d = sum_q + SUM_W'(bus.in_data);
    if (cnt_q == '0) begin
      min_d = bus.in_data;
      max_d = bus.in_data;
    end else begin
      min_d = min_of(min_q, bus.in_data);
      max_d = max_of(max_q, bus.in_data);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      sum_q <= '0;
      min_q <= '0;
      max_q <= '0;
    end else if (accept) begin
      if (last) begin
        cnt_q <= '0;
        sum_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
        sum_q <= sum_d;
      end
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  // Result registers are written only on the block-closing accept, so they
  // stay frozen for as long as the result is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      avg_out_q <= '0;
      min_out_q <= '0;
      max_out_q <= '0;
      seq_q     <= '0;
    end else begin
      if (last) begin
        avg_out_q <= trunc_avg(sum_d);
        min_out_q <= min_d;
        max_out_q <= max_d;
      end
      if (take) begin
        seq_q <= seq_q + 16'd1;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == RESULT);
  assign bus.out_avg   = avg_out_q;
  assign bus.out_min   = min_out_q;
  assign bus.out_max   = max_out_q;
  assign bus.out_seq   = seq_q;

endmodule
